// File: rtl/dff_univ_reg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : dff_univ_reg                                                     |
// | Purpose  : WIDTH-bit universal register (load/shift/rotate/clear/invert)   |
// |            with a word-serialisation counter and one-cycle done pulse.     |
// | Revision : 1.0 - initial release                                           |
// +-----------------------------------------------------------------------------+
module dff_univ_reg #(
  parameter int unsigned          WIDTH     = 8,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             sout_r,
  output logic             sout_l,
  output logic             done
);

  localparam int unsigned          c_cntw = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_cntw-1:0]    c_last = c_cntw'(WIDTH - 1);

  localparam logic [2:0] c_mode_hold  = 3'b000;
  localparam logic [2:0] c_mode_shr   = 3'b001;
  localparam logic [2:0] c_mode_shl   = 3'b010;
  localparam logic [2:0] c_mode_load  = 3'b011;
  localparam logic [2:0] c_mode_rotr  = 3'b100;
  localparam logic [2:0] c_mode_rotl  = 3'b101;
  localparam logic [2:0] c_mode_clr   = 3'b110;
  localparam logic [2:0] c_mode_inv   = 3'b111;

  logic [WIDTH-1:0]  r_q;
  logic [c_cntw-1:0] r_cnt;
  logic              r_done;

  logic [WIDTH-1:0]  w_q_nxt;
  logic [c_cntw-1:0] w_cnt_nxt;
  logic              w_done_nxt;
  logic              w_count;

  // Data path: next register contents for each mode; unknown modes hold.
  always_comb begin
    w_q_nxt = r_q;
    w_count = 1'b0;
    if (en) begin
      case (mode)
        c_mode_hold: w_q_nxt = r_q;
        c_mode_shr: begin
          w_q_nxt = {sin, r_q[WIDTH-1:1]};
          w_count = 1'b1;
        end
        c_mode_shl: begin
          w_q_nxt = {r_q[WIDTH-2:0], sin};
          w_count = 1'b1;
        end
        c_mode_load: w_q_nxt = d;
        c_mode_rotr: begin
          w_q_nxt = {r_q[0], r_q[WIDTH-1:1]};
          w_count = 1'b1;
        end
        c_mode_rotl: begin
          w_q_nxt = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
          w_count = 1'b1;
        end
        c_mode_clr: w_q_nxt = RESET_VAL;
        c_mode_inv: w_q_nxt = ~r_q;
        default:    w_q_nxt = r_q;
      endcase
    end
  end

  // Shift counter: any direction counts; load and sync clear restart the word.
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_done_nxt = 1'b0;
    if (w_count) begin
      if (r_cnt == c_last) begin
        w_cnt_nxt  = '0;
        w_done_nxt = 1'b1;
      end else begin
        w_cnt_nxt  = r_cnt + 1'b1;
      end
    end else if (en && (mode == c_mode_load || mode == c_mode_clr)) begin
      w_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_q    <= RESET_VAL;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_q    <= w_q_nxt;
      r_cnt  <= w_cnt_nxt;
      r_done <= w_done_nxt;
    end
  end

  assign q      = r_q;
  assign qb     = ~r_q;
  assign sout_r = r_q[0];
  assign sout_l = r_q[WIDTH-1];
  assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_dff_univ_reg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_dff_univ_reg                                                  |
// | Purpose  : directed self-checking bench for dff_univ_reg (WIDTH=8, A5)     |
// | Revision : 1.0 - initial release                                           |
// +-----------------------------------------------------------------------------+
module tb_dff_univ_reg;

  localparam int unsigned      c_w   = 8;
  localparam logic [c_w-1:0]   c_rst = 8'hA5;

  logic           clk;
  logic           clear;
  logic           en;
  logic [2:0]     mode;
  logic [c_w-1:0] d;
  logic           sin;
  logic [c_w-1:0] q;
  logic [c_w-1:0] qb;
  logic           sout_r;
  logic           sout_l;
  logic           done;

  int checks   = 0;
  int failures = 0;

  dff_univ_reg #(.WIDTH(c_w), .RESET_VAL(c_rst)) dut (
    .clk    (clk),
    .clear  (clear),
    .en     (en),
    .mode   (mode),
    .d      (d),
    .sin    (sin),
    .q      (q),
    .qb     (qb),
    .sout_r (sout_r),
    .sout_l (sout_l),
    .done   (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [2:0] m, input logic [c_w-1:0] dv, input logic s);
    en = e; mode = m; d = dv; sin = s;
  endtask

  logic [7:0] exp_sr;

  initial begin
    clear = 1'b1;
    drive(1'b0, 3'b000, 8'h00, 1'b0);

    // Reset asserted mid-cycle must act before any clock edge.
    #2 clear = 1'b0;
    #1;
    chk("rst_q", q, 8'hA5);
    chk("rst_qb", qb, 8'h5A);
    chk("rst_done", done, 1'b0);
    chk("rst_sout", {sout_l, sout_r}, 2'b11);
    step();
    #2 clear = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("en0_hold_q", q, 8'hA5);
    end

    // Load and complement
    drive(1'b1, 3'b011, 8'h3C, 1'b0);
    step();
    chk("load_q", q, 8'h3C);
    chk("load_qb", qb, 8'hC3);
    chk("load_sout", {sout_l, sout_r}, 2'b00);
    drive(1'b1, 3'b111, 8'h00, 1'b0);
    step();
    chk("inv_q", q, 8'hC3);
    chk("inv_done", done, 1'b0);

    // Serialise right: B2 out LSB first with sin=0
    drive(1'b1, 3'b011, 8'hB2, 1'b0);
    step();
    exp_sr = 8'b1011_0010;
    drive(1'b1, 3'b001, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("ser_sout_r", sout_r, exp_sr[i]);
      step();
      chk("ser_done", done, (i == 7) ? 1'b1 : 1'b0);
    end
    chk("ser_q", q, 8'h00);
    drive(1'b1, 3'b000, 8'h00, 1'b0);
    step();
    chk("ser_done_pulse", done, 1'b0);

    // Rotate left 4, pause with en=0, rotate right 4
    drive(1'b1, 3'b011, 8'h81, 1'b0);
    step();
    drive(1'b1, 3'b101, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rotl_done", done, 1'b0);
    end
    chk("rotl_q", q, 8'h18);
    drive(1'b0, 3'b100, 8'h00, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rot_pause_q", q, 8'h18);
      chk("rot_pause_done", done, 1'b0);
    end
    drive(1'b1, 3'b100, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rotr_done", done, (i == 3) ? 1'b1 : 1'b0);
    end
    chk("rotr_q", q, 8'h81);

    // Interrupted count: reload restarts the word
    drive(1'b1, 3'b011, 8'h5A, 1'b0);
    step();
    drive(1'b1, 3'b001, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("intr_pre_done", done, 1'b0);
    end
    drive(1'b1, 3'b011, 8'hFF, 1'b0);
    step();
    chk("intr_reload_q", q, 8'hFF);
    drive(1'b1, 3'b010, 8'h00, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("intr_q", q, 8'hFF);
      chk("intr_done", done, (i == 7) ? 1'b1 : 1'b0);
    end

    // Async reset mid-serialisation discards the partial count
    drive(1'b1, 3'b011, 8'h0F, 1'b0);
    step();
    drive(1'b1, 3'b001, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) step();
    clear = 1'b0;
    #1;
    chk("arst_q", q, 8'hA5);
    chk("arst_qb", qb, 8'h5A);
    chk("arst_done", done, 1'b0);
    #2 clear = 1'b1;
    drive(1'b1, 3'b001, 8'h00, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("arst_shift_done", done, (i == 7) ? 1'b1 : 1'b0);
    end
    chk("arst_shift_q", q, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dff_univ_reg.md
# dff_univ_reg

Parametrised successor to the single-bit D flip-flop: a WIDTH-bit universal register with complementary outputs, parallel load, shift/rotate in both directions, synchronous clear and bitwise invert. A built-in shift counter flags when a full word has been serialised. It is the storage and serialisation primitive for datapath and serial-link blocks that previously chained individual D flip-flops.

## Interface

- WIDTH, 8: register width in bits; legal range 2..32.
- RESET_VAL, 0: value loaded into q on reset and on synchronous clear; WIDTH bits.

- clk  in  1  rising-edge clock; all state changes on its rising edge except reset.
- clear  in  1  asynchronous, active-low reset; clear=0 forces reset state immediately, independent of clk.
- en  in  1  operation enable; en=0 holds all state regardless of mode.
- mode  in  3  operation select, sampled at the rising edge when en=1.
- d  in  WIDTH  parallel load data.
- sin  in  1  serial input for shift modes.
- q  out  WIDTH  register contents.
- qb  out  WIDTH  bitwise complement of q, combinational from q.
- sout_r  out  1  q[0], combinational; bit leaving on a right shift.
- sout_l  out  1  q[WIDTH-1], combinational; bit leaving on a left shift.
- done  out  1  registered one-cycle pulse: WIDTH shift/rotate operations completed since the last load or clear.

## Operation

- Modes, applied at the rising edge when en=1:
  - 000 hold: q unchanged.
  - 001 shift right: q <= {sin, q[WIDTH-1:1]}.
  - 010 shift left: q <= {q[WIDTH-2:0], sin}.
  - 011 load: q <= d.
  - 100 rotate right: q <= {q[0], q[WIDTH-1:1]}.
  - 101 rotate left: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - 110 sync clear: q <= RESET_VAL.
  - 111 invert: q <= ~q.
- Shift counter cnt (internal, width ceil(log2(WIDTH)), reset 0):
  - Modes 001/010/100/101 with en=1: cnt increments. When cnt == WIDTH-1 before the edge, cnt wraps to 0 and done is 1 for the next cycle.
  - Modes 011 and 110 with en=1: cnt <= 0. done <= 0.
  - Modes 000 and 111, or en=0: cnt unchanged. done <= 0.
  - Direction changes do not reset cnt. Mixing left and right shifts still counts toward WIDTH.
- Reset (clear=0): q=RESET_VAL, qb=~RESET_VAL, cnt=0, done=0. sout_r and sout_l follow q. Reset takes effect immediately, including mid-serialisation; the partial count is discarded.
- Unknown or X mode: treated as hold. The bench does not drive X after reset.

## Timing

- Latency: q, cnt and done update 1 clock after the edge that samples en/mode/d/sin. qb, sout_r and sout_l follow q combinationally, with zero cycles of added latency.
- done is high for exactly one cycle. It goes high in the cycle after the WIDTH-th counted shift. It re-asserts every WIDTH further shifts if shifting continues.
- A load in the same cycle that done is high does not cancel that done pulse. It only restarts the count.
- Reset assertion is asynchronous. Reset release is seen at the first rising edge with clear=1. The bench releases clear at least 1 ns away from a clock edge.
- No combinational path exists from any input to q or done.

## Test plan

- Reset: clear=0 mid-cycle with WIDTH=8, RESET_VAL=8'hA5 -> q=A5, qb=5A, done=0 immediately. Release, then 3 cycles with en=0 -> q stays A5.
- Load and complement: en=1, mode=011, d=3C -> next cycle q=3C, qb=C3, sout_l=0, sout_r=0. Then mode=111 -> q=C3.
- Serialise right: load 8'b1011_0010, then 8 cycles of mode=001 with sin=0 -> sout_r sequence before each edge is 0,1,0,0,1,1,0,1. Final q=00. done=1 only in the cycle after the 8th shift.
- Rotate and counter: load 81, then 4× mode=101 -> q=18. Then 4× mode=100 -> q=81, with done=1 after the 8th rotate. en=0 for 2 cycles in the middle does not advance the count.
- Interrupted count: load, 5 shifts, then mode=011 (d=FF), then 8 shifts left with sin=1 -> no done after the first 5 shifts. done fires only after the 8th shift following the reload; q=FF throughout.
- Async reset mid-serialisation: load, 6 shifts, pulse clear=0 between edges -> q=RESET_VAL at once. After release, 2 shifts give no done; done first appears after 8 shifts.
